// File: rtl/io_seg_pkg.sv
// Shared constants for the 7-segment scan controller: bus addresses,
// CTRL bit positions, blank glyph and CTRL reset value.
package io_seg_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_CTRL   = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;

    localparam int CTRL_MASK_LSB = 0;
    localparam int CTRL_EN       = 4;
    localparam int CTRL_HEX      = 5;

    // Segments are active-low, so all-ones is a dark digit.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Display enabled, no blinking, raw segment mode.
    localparam logic [5:0] CTRL_RST = 6'b01_0000;

endpackage

// File: rtl/seg_hex7.sv
// Combinational hex-to-glyph decoder. Output is active-low {dp,g..a}
// with the decimal point always off.
module seg_hex7 (
    input  logic [3:0] nib,
    output logic [7:0] seg
);

    // Fixed glyph table for 0-9, A-F.
    always_comb begin
        seg = 8'hFF;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end

endmodule

// File: rtl/io_seg_scan_ctrl.sv
// Bus-facing controller for a 4-digit 7-segment display driver.
// Owns scan/blink timing and the DATA/CTRL registers; DATA reaches the
// display through a shadow register that only reloads at frame boundaries
// so a frame never shows a mix of old and new bytes.
// Optional hex decoding is built when SEG_HEX_DECODE_EN is defined;
// otherwise CTRL[5] is tied to 0 and only raw segment bytes are shown.
module io_seg_scan_ctrl
    import io_seg_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [1:0]  addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic [1:0]  scan,
    output logic        flash,
    output logic [31:0] disp_data
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [1:0]    scan_q, scan_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;
    logic [31:0]   data_q, data_d;
    logic [31:0]   shadow_q, shadow_d;
    logic          loaded_q, loaded_d;
    logic [5:0]    ctrl_q, ctrl_d;
    logic [31:0]   disp_q, disp_d;
    logic          flash_q, flash_d;
    logic [31:0]   rdata_q, rdata_d;

    logic tick;
    logic frame_end;
    logic blink_wrap;
    logic data_we;
    logic ctrl_we;
    logic [7:0] glyph [4];

`ifdef SEG_HEX_DECODE_EN
    // One decoder per digit; digit k takes nibble shadow[15-4k -: 4].
    for (genvar g = 0; g < 4; g++) begin : g_hex
        seg_hex7 u_hex (
            .nib (shadow_q[15-4*g -: 4]),
            .seg (glyph[g])
        );
    end
`else
    // No decoder in raw-only builds.
    always_comb begin
        for (int k = 0; k < 4; k++) glyph[k] = SEG_BLANK;
    end
`endif

    // Scan prescaler, digit select and blink timing.
    always_comb begin
        tick          = (prescaler_q == PW'(SCAN_DIV - 1));
        prescaler_d   = tick ? '0 : prescaler_q + 1'b1;
        scan_d        = tick ? scan_q + 2'd1 : scan_q;
        frame_end     = tick && (scan_q == 2'd3);
        blink_wrap    = (blink_cnt_q == BW'(BLINK_FRAMES - 1));
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_end) begin
            if (blink_wrap) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end
    end

    // Register writes, shadow reload and registered read mux.
    always_comb begin
        data_we  = we && (addr == ADDR_DATA);
        ctrl_we  = we && (addr == ADDR_CTRL);
        data_d   = data_we ? wdata : data_q;
        ctrl_d   = ctrl_q;
        if (ctrl_we) begin
`ifdef SEG_HEX_DECODE_EN
            ctrl_d = wdata[5:0];
`else
            ctrl_d = {1'b0, wdata[4:0]};
`endif
        end
        // A DATA write landing on frame_end is forwarded so it is not a frame late.
        shadow_d = shadow_q;
        if (frame_end) shadow_d = data_we ? wdata : data_q;
        loaded_d = loaded_q | frame_end;
        case (addr)
            ADDR_DATA:   rdata_d = data_q;
            ADDR_CTRL:   rdata_d = {26'b0, ctrl_q};
            ADDR_STATUS: rdata_d = {29'b0, blink_phase_q, scan_q};
            default:     rdata_d = 32'b0;
        endcase
    end

    // Per-digit segment selection; dark until the first frame has loaded the shadow.
    always_comb begin
        disp_d  = {4{SEG_BLANK}};
        flash_d = blink_phase_q & ctrl_q[CTRL_EN];
        for (int k = 0; k < 4; k++) begin
            if (!loaded_q || !ctrl_q[CTRL_EN]) begin
                disp_d[31-8*k -: 8] = SEG_BLANK;
            end else if (ctrl_q[CTRL_MASK_LSB + k] && blink_phase_q) begin
                disp_d[31-8*k -: 8] = SEG_BLANK;
            end else if (ctrl_q[CTRL_HEX]) begin
                disp_d[31-8*k -: 8] = glyph[k];
            end else begin
                disp_d[31-8*k -: 8] = shadow_q[31-8*k -: 8];
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescaler_q   <= '0;
            scan_q        <= 2'd0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            data_q        <= 32'b0;
            shadow_q      <= 32'b0;
            loaded_q      <= 1'b0;
            ctrl_q        <= CTRL_RST;
            disp_q        <= {4{SEG_BLANK}};
            flash_q       <= 1'b0;
            rdata_q       <= 32'b0;
        end else begin
            prescaler_q   <= prescaler_d;
            scan_q        <= scan_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            data_q        <= data_d;
            shadow_q      <= shadow_d;
            loaded_q      <= loaded_d;
            ctrl_q        <= ctrl_d;
            disp_q        <= disp_d;
            flash_q       <= flash_d;
            rdata_q       <= rdata_d;
        end
    end

    assign scan      = scan_q;
    assign flash     = flash_q;
    assign disp_data = disp_q;
    assign rdata     = rdata_q;

endmodule
